// File: rtl/tlb_pkg.sv
// Shared types and width helpers for the LRU-managed TLB.
package tlb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        WB   = 2'd2,
        FILL = 2'd3
    } tlb_state_t;

    function automatic int vpn_width(input int va_w, input int page_off);
        return va_w - page_off;
    endfunction

    function automatic int ppn_width(input int pa_w, input int page_off);
        return pa_w - page_off;
    endfunction

    function automatic int age_width(input int entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/tlb_lru_age.sv
// True-LRU age bookkeeping for the TLB rows plus victim selection
// (lowest invalid row first, otherwise the oldest row).
module tlb_lru_age
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int AGE_W   = age_width(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               touch,
    input  logic [AGE_W-1:0]   touch_idx,
    input  logic [ENTRIES-1:0] valid_vec,
    output logic [AGE_W-1:0]   victim_idx
);

    logic [AGE_W-1:0] age_q [ENTRIES];
    logic [AGE_W-1:0] age_d [ENTRIES];
    logic             found_invalid;

    // Rows younger than the touched one age by one; the touched row becomes newest.
    always_comb begin
        age_d = age_q;
        if (touch) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (age_q[j] < age_q[touch_idx]) begin
                    age_d[j] = age_q[j] + 1'b1;
                end
            end
            age_d[touch_idx] = '0;
        end
    end

    always_comb begin
        victim_idx    = '0;
        found_invalid = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!found_invalid && !valid_vec[i]) begin
                victim_idx    = AGE_W'(i);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (age_q[i] == AGE_W'(ENTRIES - 1)) begin
                    victim_idx = AGE_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                age_q[i] <= AGE_W'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/tlb_lru_ctrl.sv
// TLB with registered 1-cycle hit path, miss handling over a page-table
// req/done handshake and write-back of dirty LRU victims.
module tlb_lru_ctrl
    import tlb_pkg::*;
#(
    parameter int VA_W     = 14,
    parameter int PA_W     = 10,
    parameter int PAGE_OFF = 8,
    parameter int ENTRIES  = 4,
    parameter int VPN_W    = vpn_width(VA_W, PAGE_OFF),
    parameter int PPN_W    = ppn_width(PA_W, PAGE_OFF),
    parameter int AGE_W    = age_width(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [VA_W-1:0]  req_vaddr,
    output logic             req_ready,
    input  logic             flush,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [PA_W-1:0]  resp_paddr,
    output logic             pt_req_valid,
    output logic             pt_write,
    output logic [VPN_W-1:0] pt_vpn,
    output logic [PPN_W-1:0] pt_ppn_wr,
    input  logic             pt_done,
    input  logic [PPN_W-1:0] pt_ppn_rd
);

    tlb_state_t         state_q, state_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] dirty_q, dirty_d;
    logic [VPN_W-1:0]   tag_q [ENTRIES];
    logic [VPN_W-1:0]   tag_d [ENTRIES];
    logic [PPN_W-1:0]   ppn_q [ENTRIES];
    logic [PPN_W-1:0]   ppn_d [ENTRIES];
    logic [VA_W-1:0]    vaddr_q, vaddr_d;
    logic               write_q, write_d;
    logic [AGE_W-1:0]   victim_q, victim_d;
    logic               resp_hit_q, resp_hit_d;
    logic [PA_W-1:0]    resp_paddr_q, resp_paddr_d;

    logic               hit;
    logic [AGE_W-1:0]   hit_idx;
    logic               touch;
    logic [AGE_W-1:0]   touch_idx;
    logic [AGE_W-1:0]   lru_victim;

    tlb_lru_age #(
        .ENTRIES (ENTRIES),
        .AGE_W   (AGE_W)
    ) u_age (
        .clk        (clk),
        .rst_n      (rst_n),
        .touch      (touch),
        .touch_idx  (touch_idx),
        .valid_vec  (valid_q),
        .victim_idx (lru_victim)
    );

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == req_vaddr[VA_W-1:PAGE_OFF]) begin
                hit     = 1'b1;
                hit_idx = AGE_W'(i);
            end
        end
    end

    // Victim index is frozen at miss time so WB and FILL address the same row.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        ppn_d        = ppn_q;
        vaddr_d      = vaddr_q;
        write_d      = write_q;
        victim_d     = victim_q;
        resp_hit_d   = resp_hit_q;
        resp_paddr_d = resp_paddr_q;
        touch        = 1'b0;
        touch_idx    = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    vaddr_d = req_vaddr;
                    write_d = req_write;
                    if (hit) begin
                        state_d      = RESP;
                        resp_hit_d   = 1'b1;
                        resp_paddr_d = {ppn_q[hit_idx], req_vaddr[PAGE_OFF-1:0]};
                        touch        = 1'b1;
                        touch_idx    = hit_idx;
                        if (req_write) begin
                            dirty_d[hit_idx] = 1'b1;
                        end
                    end else begin
                        victim_d = lru_victim;
                        state_d  = (valid_q[lru_victim] && dirty_q[lru_victim]) ? WB : FILL;
                    end
                end else if (flush) begin
                    valid_d = '0;
                    dirty_d = '0;
                end
            end
            WB: begin
                if (pt_done) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (pt_done) begin
                    valid_d[victim_q] = 1'b1;
                    dirty_d[victim_q] = write_q;
                    tag_d[victim_q]   = vaddr_q[VA_W-1:PAGE_OFF];
                    ppn_d[victim_q]   = pt_ppn_rd;
                    touch             = 1'b1;
                    touch_idx         = victim_q;
                    resp_hit_d        = 1'b0;
                    resp_paddr_d      = {pt_ppn_rd, vaddr_q[PAGE_OFF-1:0]};
                    state_d           = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready    = (state_q == IDLE);
        resp_valid   = (state_q == RESP);
        resp_hit     = resp_hit_q;
        resp_paddr   = resp_paddr_q;
        pt_req_valid = (state_q == WB) || (state_q == FILL);
        pt_write     = (state_q == WB);
        pt_vpn       = '0;
        pt_ppn_wr    = '0;
        if (state_q == WB) begin
            pt_vpn    = tag_q[victim_q];
            pt_ppn_wr = ppn_q[victim_q];
        end else if (state_q == FILL) begin
            pt_vpn = vaddr_q[VA_W-1:PAGE_OFF];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            vaddr_q      <= '0;
            write_q      <= 1'b0;
            victim_q     <= '0;
            resp_hit_q   <= 1'b0;
            resp_paddr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ppn_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            tag_q        <= tag_d;
            ppn_q        <= ppn_d;
            vaddr_q      <= vaddr_d;
            write_q      <= write_d;
            victim_q     <= victim_d;
            resp_hit_q   <= resp_hit_d;
            resp_paddr_q <= resp_paddr_d;
        end
    end

endmodule

// File: tb/tb_tlb_lru_ctrl.sv
// Directed self-checking bench for tlb_lru_ctrl with default parameters.
module tb_tlb_lru_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [13:0] req_vaddr;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic        resp_hit;
    logic [9:0]  resp_paddr;
    logic        pt_req_valid;
    logic        pt_write;
    logic [5:0]  pt_vpn;
    logic [1:0]  pt_ppn_wr;
    logic        pt_done;
    logic [1:0]  pt_ppn_rd;

    int checks   = 0;
    int failures = 0;

    logic       r_hit;
    logic [9:0] r_paddr;
    logic       r_wb;
    logic [5:0] r_wb_vpn;
    logic [1:0] r_wb_ppn;
    logic [5:0] r_fill_vpn;
    int         r_lat;

    tlb_lru_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_vaddr    (req_vaddr),
        .req_ready    (req_ready),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_paddr   (resp_paddr),
        .pt_req_valid (pt_req_valid),
        .pt_write     (pt_write),
        .pt_vpn       (pt_vpn),
        .pt_ppn_wr    (pt_ppn_wr),
        .pt_done      (pt_done),
        .pt_ppn_rd    (pt_ppn_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_vaddr = '0;
        flush     = 1'b0;
        pt_done   = 1'b0;
        pt_ppn_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
    endtask

    // Issues one request and services every page-table transaction with ppn_val.
    task automatic access(input logic [13:0] va, input logic wr, input logic fl,
                          input logic [1:0] ppn_val);
        bit got;
        got        = 1'b0;
        r_hit      = 1'bx;
        r_paddr    = 'x;
        r_wb       = 1'b0;
        r_wb_vpn   = '0;
        r_wb_ppn   = '0;
        r_fill_vpn = '0;
        r_lat      = -1;
        req_valid  = 1'b1;
        req_write  = wr;
        req_vaddr  = va;
        flush      = fl;
        @(posedge clk) #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        flush     = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (resp_valid) begin
                r_hit   = resp_hit;
                r_paddr = resp_paddr;
                r_lat   = c;
                got     = 1'b1;
            end else if (pt_req_valid) begin
                if (pt_write) begin
                    r_wb     = 1'b1;
                    r_wb_vpn = pt_vpn;
                    r_wb_ppn = pt_ppn_wr;
                end else begin
                    r_fill_vpn = pt_vpn;
                end
                pt_done   = 1'b1;
                pt_ppn_rd = ppn_val;
                @(posedge clk) #1;
                pt_done = 1'b0;
            end else begin
                @(posedge clk) #1;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL access_timeout va=%h got=no_response exp=response", va);
        end
        @(posedge clk) #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (pt_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_pt_req_valid got=%b exp=0", pt_req_valid); end
        checks++; if (resp_paddr !== 10'h000 || resp_hit !== 1'b0) begin failures++; $display("[TB] FAIL rst_resp got=%h/%b exp=000/0", resp_paddr, resp_hit); end
        checks++; if (pt_vpn !== 6'h00 || pt_write !== 1'b0 || pt_ppn_wr !== 2'd0) begin failures++; $display("[TB] FAIL rst_pt_fields got=%h/%b/%h exp=00/0/0", pt_vpn, pt_write, pt_ppn_wr); end
    endtask

    task automatic test_miss_then_hit();
        do_reset();
        access(14'h0A5C, 1'b0, 1'b0, 2'd2);
        checks++; if (r_fill_vpn !== 6'h0A) begin failures++; $display("[TB] FAIL t1_fill_vpn got=%h exp=0a", r_fill_vpn); end
        checks++; if (r_paddr !== 10'h25C || r_hit !== 1'b0) begin failures++; $display("[TB] FAIL t1_miss_resp got=%h/%b exp=25c/0", r_paddr, r_hit); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL t1_resp_pulse got=%b exp=0", resp_valid); end
        checks++; if (resp_paddr !== 10'h25C) begin failures++; $display("[TB] FAIL t1_paddr_hold got=%h exp=25c", resp_paddr); end
        access(14'h0A5C, 1'b0, 1'b0, 2'd0);
        checks++; if (r_hit !== 1'b1 || r_paddr !== 10'h25C) begin failures++; $display("[TB] FAIL t1_hit_resp got=%h/%b exp=25c/1", r_paddr, r_hit); end
        checks++; if (r_lat !== 0) begin failures++; $display("[TB] FAIL t1_hit_latency got=%0d exp=0", r_lat); end
    endtask

    task automatic test_lru_victim();
        do_reset();
        access(14'h0100, 1'b0, 1'b0, 2'd0);
        access(14'h0200, 1'b0, 1'b0, 2'd1);
        access(14'h0300, 1'b0, 1'b0, 2'd2);
        access(14'h0400, 1'b0, 1'b0, 2'd3);
        access(14'h0100, 1'b0, 1'b0, 2'd0);
        checks++; if (r_hit !== 1'b1) begin failures++; $display("[TB] FAIL t2_hit_vpn1 got=%b exp=1", r_hit); end
        access(14'h0501, 1'b0, 1'b0, 2'd1);
        checks++; if (r_hit !== 1'b0 || r_wb !== 1'b0 || r_paddr !== 10'h101) begin failures++; $display("[TB] FAIL t2_vpn5 got=%b/%b/%h exp=0/0/101", r_hit, r_wb, r_paddr); end
        access(14'h0202, 1'b0, 1'b0, 2'd3);
        checks++; if (r_hit !== 1'b0 || r_paddr !== 10'h302) begin failures++; $display("[TB] FAIL t2_vpn2_evicted got=%b/%h exp=0/302", r_hit, r_paddr); end
        access(14'h0112, 1'b0, 1'b0, 2'd1);
        checks++; if (r_hit !== 1'b1 || r_paddr !== 10'h012) begin failures++; $display("[TB] FAIL t2_vpn1_kept got=%b/%h exp=1/012", r_hit, r_paddr); end
        access(14'h0433, 1'b0, 1'b0, 2'd0);
        checks++; if (r_hit !== 1'b1 || r_paddr !== 10'h333) begin failures++; $display("[TB] FAIL t2_vpn4_kept got=%b/%h exp=1/333", r_hit, r_paddr); end
    endtask

    task automatic test_dirty_writeback();
        do_reset();
        access(14'h0100, 1'b0, 1'b0, 2'd0);
        access(14'h0200, 1'b0, 1'b0, 2'd1);
        access(14'h0300, 1'b0, 1'b0, 2'd2);
        access(14'h0400, 1'b0, 1'b0, 2'd3);
        access(14'h0180, 1'b1, 1'b0, 2'd3);
        checks++; if (r_hit !== 1'b1 || r_paddr !== 10'h080) begin failures++; $display("[TB] FAIL t3_write_hit got=%b/%h exp=1/080", r_hit, r_paddr); end
        access(14'h0200, 1'b0, 1'b0, 2'd0);
        access(14'h0300, 1'b0, 1'b0, 2'd0);
        access(14'h0400, 1'b0, 1'b0, 2'd0);
        checks++; if (r_hit !== 1'b1) begin failures++; $display("[TB] FAIL t3_vpn4_hit got=%b exp=1", r_hit); end
        access(14'h0600, 1'b0, 1'b0, 2'd1);
        checks++; if (r_wb !== 1'b1 || r_wb_vpn !== 6'h01 || r_wb_ppn !== 2'd0) begin failures++; $display("[TB] FAIL t3_writeback got=%b/%h/%h exp=1/01/0", r_wb, r_wb_vpn, r_wb_ppn); end
        checks++; if (r_fill_vpn !== 6'h06 || r_hit !== 1'b0 || r_paddr !== 10'h100) begin failures++; $display("[TB] FAIL t3_fill got=%h/%b/%h exp=06/0/100", r_fill_vpn, r_hit, r_paddr); end
    endtask

    task automatic test_slow_pt();
        bit ok;
        do_reset();
        access(14'h0100, 1'b1, 1'b0, 2'd3);
        access(14'h0200, 1'b0, 1'b0, 2'd1);
        access(14'h0300, 1'b0, 1'b0, 2'd2);
        access(14'h0400, 1'b0, 1'b0, 2'd0);
        req_valid = 1'b1;
        req_vaddr = 14'h0733;
        @(posedge clk) #1;
        req_valid = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (req_ready !== 1'b0 || pt_req_valid !== 1'b1 || pt_write !== 1'b1 ||
                pt_vpn !== 6'h01 || pt_ppn_wr !== 2'd3) ok = 1'b0;
            @(posedge clk) #1;
        end
        checks++; if (!ok) begin failures++; $display("[TB] FAIL t4_wb_stable got=%b/%b/%b/%h/%h exp=0/1/1/01/3", req_ready, pt_req_valid, pt_write, pt_vpn, pt_ppn_wr); end
        pt_done = 1'b1;
        @(posedge clk) #1;
        pt_done = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (req_ready !== 1'b0 || pt_req_valid !== 1'b1 || pt_write !== 1'b0 ||
                pt_vpn !== 6'h07) ok = 1'b0;
            @(posedge clk) #1;
        end
        checks++; if (!ok) begin failures++; $display("[TB] FAIL t4_fill_stable got=%b/%b/%b/%h exp=0/1/0/07", req_ready, pt_req_valid, pt_write, pt_vpn); end
        pt_done   = 1'b1;
        pt_ppn_rd = 2'd2;
        @(posedge clk) #1;
        pt_done = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_paddr !== 10'h233) begin failures++; $display("[TB] FAIL t4_resp got=%b/%b/%h exp=1/0/233", resp_valid, resp_hit, resp_paddr); end
        @(posedge clk) #1;
        pt_done   = 1'b1;
        pt_ppn_rd = 2'd1;
        @(posedge clk) #1;
        pt_done = 1'b0;
        checks++; if (req_ready !== 1'b1 || pt_req_valid !== 1'b0 || resp_valid !== 1'b0 || resp_paddr !== 10'h233) begin failures++; $display("[TB] FAIL t4_stray_done got=%b/%b/%b/%h exp=1/0/0/233", req_ready, pt_req_valid, resp_valid, resp_paddr); end
        access(14'h0711, 1'b0, 1'b0, 2'd0);
        checks++; if (r_hit !== 1'b1 || r_paddr !== 10'h211) begin failures++; $display("[TB] FAIL t4_vpn7_hit got=%b/%h exp=1/211", r_hit, r_paddr); end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        req_valid = 1'b1;
        req_vaddr = 14'h0900;
        @(posedge clk) #1;
        req_valid = 1'b0;
        checks++; if (pt_req_valid !== 1'b1 || pt_vpn !== 6'h09) begin failures++; $display("[TB] FAIL t5_in_fill got=%b/%h exp=1/09", pt_req_valid, pt_vpn); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pt_req_valid !== 1'b0 || pt_vpn !== 6'h00 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL t5_async_reset got=%b/%h/%b/%b exp=0/00/1/0", pt_req_valid, pt_vpn, req_ready, resp_valid); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        access(14'h0955, 1'b0, 1'b0, 2'd1);
        checks++; if (r_hit !== 1'b0 || r_fill_vpn !== 6'h09 || r_paddr !== 10'h155) begin failures++; $display("[TB] FAIL t5_refill got=%b/%h/%h exp=0/09/155", r_hit, r_fill_vpn, r_paddr); end
    endtask

    task automatic test_flush();
        do_reset();
        access(14'h0110, 1'b1, 1'b0, 2'd1);
        access(14'h0220, 1'b0, 1'b0, 2'd2);
        flush = 1'b1;
        @(posedge clk) #1;
        flush = 1'b0;
        checks++; if (pt_req_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL t6_flush_idle got=%b/%b exp=0/1", pt_req_valid, req_ready); end
        access(14'h0110, 1'b0, 1'b0, 2'd3);
        checks++; if (r_hit !== 1'b0 || r_wb !== 1'b0 || r_paddr !== 10'h310) begin failures++; $display("[TB] FAIL t6_vpn1_after_flush got=%b/%b/%h exp=0/0/310", r_hit, r_wb, r_paddr); end
        access(14'h0220, 1'b0, 1'b0, 2'd0);
        checks++; if (r_hit !== 1'b0 || r_paddr !== 10'h020) begin failures++; $display("[TB] FAIL t6_vpn2_after_flush got=%b/%h exp=0/020", r_hit, r_paddr); end
        access(14'h0144, 1'b0, 1'b1, 2'd0);
        checks++; if (r_hit !== 1'b1 || r_paddr !== 10'h344) begin failures++; $display("[TB] FAIL t6_flush_with_req got=%b/%h exp=1/344", r_hit, r_paddr); end
        access(14'h0220, 1'b0, 1'b0, 2'd1);
        checks++; if (r_hit !== 1'b1 || r_paddr !== 10'h020) begin failures++; $display("[TB] FAIL t6_contents_kept got=%b/%h exp=1/020", r_hit, r_paddr); end
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_lru_victim();
        test_dirty_writeback();
        test_slow_pt();
        test_reset_mid_fill();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
